// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flop,
// processing A - B LSB first over WIDTH clocks under a three-state controller.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iMinuend,
    input  logic [WIDTH-1:0] iSubtrahend,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oDifference,
    output logic             oBorrow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Full-subtractor cell: returns {borrow_out, difference}
    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
        logic d;
        logic bout;
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
        return {bout, d};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       cell_s;

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        cell_s   = full_sub(a_q[0], b_q[0], borrow_q);

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    a_d      = iMinuend;
                    b_d      = iSubtrahend;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                // The minuend register doubles as the result register: each
                // consumed A bit frees the MSB slot for the new difference bit.
                a_d      = {cell_s[0], a_q[WIDTH-1:1]};
                b_d      = {1'b0, b_q[WIDTH-1:1]};
                borrow_d = cell_s[1];
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    diff_d  = {cell_s[0], a_q[WIDTH-1:1]};
                    bout_d  = cell_s[1];
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign oBusy       = busy_q;
    assign oDone       = done_q;
    assign oDifference = diff_q;
    assign oBorrow     = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corners, random operands
// against an arithmetic reference, start-ignore, mid-run reset abort, back-to-back.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    int checks;
    int errors;

    serial_subtractor #(.WIDTH(W)) dut (
        .iClk        (clk),
        .iRst_n      (rst_n),
        .iStart      (start),
        .iMinuend    (a),
        .iSubtrahend (b),
        .oBusy       (busy),
        .oDone       (done),
        .oDifference (diff),
        .oBorrow     (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {borrow, diff} of a (W+1)-bit unsigned subtraction
    function automatic logic [W:0] model_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} - {1'b0, y};
    endfunction

    // Launch one operation and observe W+4 cycles after the accepting edge
    task automatic run_op(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                          output logic [W-1:0] d_out, output logic bo_out,
                          output int lat, output int busy_cnt, output int done_cnt,
                          output int chg_cnt);
        logic [W-1:0] prev_d;
        logic         prev_b;
        bit           seen;
        @(negedge clk);
        prev_d = diff;
        prev_b = borrow;
        start  = 1'b1;
        a      = a_in;
        b      = b_in;
        @(negedge clk);
        start  = 1'b0;
        a      = W'($urandom);
        b      = W'($urandom);
        busy_cnt = 0; done_cnt = 0; lat = -1; chg_cnt = 0; seen = 1'b0;
        d_out = '0; bo_out = 1'b0;
        for (int j = 0; j < W + 4; j++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (!seen) begin
                    lat = j; d_out = diff; bo_out = borrow; seen = 1'b1;
                end
            end else if (!seen && (diff !== prev_d || borrow !== prev_b)) begin
                chg_cnt++;
            end else if (seen && (diff !== d_out || borrow !== bo_out)) begin
                chg_cnt++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, diff, borrow} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b diff=%h borrow=%b, required all 0", busy, done, diff, borrow);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4];
        logic [W-1:0] tb_ [4];
        logic [W-1:0] d;
        logic         bo;
        logic [W:0]   exp;
        int lat, bc, dc, cc;
        ta[0] = 8'h05; tb_[0] = 8'h03;
        ta[1] = 8'h03; tb_[1] = 8'h05;
        ta[2] = 8'h00; tb_[2] = 8'hFF;
        ta[3] = 8'hA5; tb_[3] = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb_[i], d, bo, lat, bc, dc, cc);
            exp = model_sub(ta[i], tb_[i]);
            checks++;
            if ({bo, d} !== exp) begin
                errors++;
                $display("FAIL directed_result %h-%h: got borrow=%b diff=%h, required borrow=%b diff=%h",
                         ta[i], tb_[i], bo, d, exp[W], exp[W-1:0]);
            end
            checks++;
            if (lat !== W) begin
                errors++;
                $display("FAIL directed_latency: done at %0d edges after accept, required %0d", lat, W);
            end
            checks++;
            if (bc !== W + 1) begin
                errors++;
                $display("FAIL directed_busy: busy for %0d cycles, required %0d", bc, W + 1);
            end
            checks++;
            if (dc !== 1) begin
                errors++;
                $display("FAIL directed_done_width: done high %0d cycles, required 1", dc);
            end
            checks++;
            if (cc !== 0) begin
                errors++;
                $display("FAIL directed_output_hold: outputs changed %0d times outside done entry, required 0", cc);
            end
        end
    endtask

    task automatic test_random(input int n);
        logic [W-1:0] ra, rb, d;
        logic         bo;
        logic [W:0]   exp;
        int lat, bc, dc, cc;
        for (int i = 0; i < n; i++) begin
            ra = W'($urandom);
            rb = (i % 16 == 0) ? ra : W'($urandom);
            run_op(ra, rb, d, bo, lat, bc, dc, cc);
            exp = model_sub(ra, rb);
            checks++;
            if ({bo, d} !== exp || dc !== 1 || lat !== W) begin
                errors++;
                $display("FAIL random %h-%h: got borrow=%b diff=%h done_cnt=%0d lat=%0d, required borrow=%b diff=%h done_cnt=1 lat=%0d",
                         ra, rb, bo, d, dc, lat, exp[W], exp[W-1:0], W);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dc;
        logic [W-1:0] d;
        logic bo;
        dc = 0; d = '0; bo = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 8'h09; b = 8'h04;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < W + 4; j++) begin
            if (j == 3) begin
                start = 1'b1; a = 8'h01; b = 8'h02;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                dc++; d = diff; bo = borrow;
            end
            @(negedge clk);
        end
        checks++;
        if (dc !== 1 || d !== 8'h05 || bo !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: done_cnt=%0d diff=%h borrow=%b, required 1/05/0", dc, d, bo);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_not_queued: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_abort();
        int dc, bc;
        @(negedge clk);
        start = 1'b1; a = 8'hC3; b = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, diff, borrow} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL abort_reset: busy=%b done=%b diff=%h borrow=%b, required all 0", busy, done, diff, borrow);
        end
        rst_n = 1'b1;
        dc = 0; bc = 0;
        for (int j = 0; j < 2 * W; j++) begin
            if (done !== 1'b0) dc++;
            if (busy !== 1'b0) bc++;
            @(negedge clk);
        end
        checks++;
        if (dc !== 0 || bc !== 0 || diff !== 8'h00 || borrow !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: done_cnt=%0d busy_cnt=%0d diff=%h borrow=%b, required 0/0/00/0", dc, bc, diff, borrow);
        end
    endtask

    task automatic test_back_to_back(input int n);
        logic [W:0] exp;
        int ops, last_t, bad_gap, bad_res;
        ops = 0; last_t = -1; bad_gap = 0; bad_res = 0;
        @(negedge clk);
        a = W'($urandom); b = W'($urandom);
        start = 1'b1;
        for (int t = 0; t < n * (W + 2) + 3 * W && ops < n; t++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                exp = model_sub(a, b);
                if ({borrow, diff} !== exp) begin
                    bad_res++;
                    $display("FAIL b2b_result %h-%h: got borrow=%b diff=%h, required borrow=%b diff=%h",
                             a, b, borrow, diff, exp[W], exp[W-1:0]);
                end
                if (last_t >= 0 && t - last_t !== W + 2) begin
                    bad_gap++;
                    $display("FAIL b2b_period: %0d cycles between done pulses, required %0d", t - last_t, W + 2);
                end
                last_t = t;
                ops++;
                a = W'($urandom); b = W'($urandom);
            end
        end
        start = 1'b0;
        checks++;
        if (ops !== n) begin
            errors++;
            $display("FAIL b2b_count: %0d operations completed, required %0d", ops, n);
        end
        checks++;
        if (bad_res + bad_gap !== 0) begin
            errors++;
            $display("FAIL b2b_summary: %0d wrong results, %0d wrong periods, required 0", bad_res, bad_gap);
        end
        repeat (W + 4) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        test_reset();
        test_directed();
        test_random(1500);
        test_ignore_start();
        test_abort();
        test_back_to_back(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
